uart_rx_with_buffer: RTL and testbench
======================================

// Module: uart_rx_with_buffer
//
// PURPOSE
// - UART receiver, 8N1 at 115200 baud from a 100 MHz clk; LSB first.
// - Pairs with the existing uart_tx path and its buffered TX wrapper.
// - Received bytes are pushed into a show-ahead FIFO and drained by the SD/debug control logic.
// - This gives the board a host->FPGA command channel, e.g. for triggering SD commands.
//
// PARAMETERS
// - CLK_PER_BIT  868  clk cycles per bit (100000000/115200); must be >= 8.
// - FIFO_DEPTH   16   FIFO entries; power of two, >= 2.
// - ADDR_W       4    log2(FIFO_DEPTH).
//
// PORTS
// - clk        in   1         system clock, 100 MHz.
// - rst_n      in   1         asynchronous, active-low reset.
// - rx         in   1         serial line, idle high, asynchronous to clk.
// - rd_en      in   1         pop request; ignored while empty.
// - rd_data    out  8         head of FIFO (show-ahead); 8'h00 while empty.
// - empty      out  1         FIFO holds 0 bytes.
// - full       out  1         FIFO holds FIFO_DEPTH bytes.
// - count      out  ADDR_W+1  bytes currently held, 0..FIFO_DEPTH.
// - overflow   out  1         sticky: a byte was dropped because the FIFO was full.
// - frame_err  out  1         sticky: stop bit (or parity) check failed.
// - clr_err    in   1         one-cycle pulse clears overflow and frame_err.
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - FSM IDLE, pointers 0, count 0.
//   - empty=1, full=0, overflow=0, frame_err=0, rd_data=0.
//   - Synchronizer flops and the previous-rx flop reset to 1.
// - Input: rx passes through 2 flops (rx_s); all sampling uses rx_s only.
// - Bit counter: down-counter; each state acts when the counter reaches 0.
// - FSM states: IDLE, START, DATA, [PARITY], STOP.
//   - IDLE: on a 1->0 edge of rx_s, go to START; counter = CLK_PER_BIT/2-1.
//   - START: at 0, sample rx_s.
//     - 1 = glitch: return to IDLE, nothing pushed, no error.
//     - 0: counter = CLK_PER_BIT-1, bit index = 0, go to DATA.
//   - DATA: at 0, shift rx_s into bit[index] and reload the counter.
//     - After bit 7, go to PARITY if compiled in, else STOP.
//   - STOP: at 0, sample rx_s.
//     - 1 = valid byte: push it.
//     - 0: set frame_err, discard the byte.
//     - Either way go to IDLE in the same cycle, so back-to-back frames are received.
// - Latency: the byte is in the FIFO one cycle after the stop-bit sample.
//   - empty falls and rd_data is valid in that same cycle.
// - FIFO:
//   - rd_data = mem[rd_ptr].
//   - rd_en && !empty advances rd_ptr on the next edge.
//   - Pointers wrap modulo FIFO_DEPTH.
// - Simultaneous events:
//   - push+pop while full: both happen, count unchanged, no overflow.
//   - push while full, no pop: byte dropped, overflow set.
//   - push+pop while empty: push only; pop ignored.
//   - clr_err in the same cycle as a set event: the set wins.
// - rst_n asserted mid-frame: the partial byte is lost and the FIFO is emptied; no error flag.
// - A line held low (break) gives one frame_err.
//   - It then waits in IDLE for a new 1->0 edge; no repeated errors.
//
// CONFIGURATION
// - UART_RX_PARITY_EN defined:
//   - Frame is 8E1: PARITY state after DATA, sampled at mid-bit.
//   - Mismatch with even parity of the data: set frame_err, discard the byte (STOP still traversed).
// - UART_RX_PARITY_EN undefined:
//   - No PARITY state and no parity logic; frame is 8N1.
//
// TESTING
// - Send 0x55 at 868 clk/bit: count=1, rd_data=8'h55, no flags; rd_en pulse -> empty=1.
// - Send 0xA5, 0x3C, 0xFF back-to-back: popped in order A5, 3C, FF; count 3 -> 0.
// - Send 17 bytes (0x00..0x10) with no reads: full=1, count=16, overflow=1.
//   - Popping returns 0x00..0x0F; clr_err clears overflow.
// - Send 0x81 with a low stop bit: frame_err=1, empty stays 1.
//   - Next good 0x42 is received as 0x42.
// - 200-cycle low glitch on idle rx: nothing pushed, no error.
//   - rst_n pulse at data bit 4: empty=1, flags 0, next 0x7E received correctly.
// - UART_RX_PARITY_EN: 0x03 with parity bit 0 -> pushed; with parity bit 1 -> frame_err, not pushed.

Source files
------------

// File: rtl/uart_rx_with_buffer.sv
// ============================================================================
// uart_rx_with_buffer : 8N1 UART receiver feeding a show-ahead byte FIFO.
// Optional 8E1 framing when UART_RX_PARITY_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_with_buffer #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clr_err
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_meta_q, rx_s_q, rx_prev_q;
  logic              push, frame_set, cnt_zero, bad_frame;

`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  assign bad_frame = par_bad_q;
`else
  assign bad_frame = 1'b0;
`endif

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic              do_pop, do_push, ovf_set;

  assign cnt_zero = (cnt_q == '0);

  // Receive FSM: every non-idle state counts down and acts on zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = FULL_LOAD;
          idx_d   = 3'd0;
          state_d = DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FULL_LOAD;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_bad_d = (rx_s_q != ^shift_q);
          cnt_d     = FULL_LOAD;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          if (!rx_s_q || bad_frame) frame_set = 1'b1;
          else                      push      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop is honoured even when full so push+pop can coexist.
  always_comb begin
    do_pop   = rd_en && (count_q != '0);
    do_push  = push && ((count_q != (ADDR_W+1)'(FIFO_DEPTH)) || do_pop);
    ovf_set  = push && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
    overflow_d  = ovf_set   ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
    frame_err_d = frame_set ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
  assign count     = count_q;
  assign rd_data   = empty ? 8'h00 : mem[rd_ptr_q];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_with_buffer.sv
// Directed self-checking bench for uart_rx_with_buffer (shortened bit period).
`default_nettype none

module tb_uart_rx_with_buffer;

  localparam int CPB    = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    rd_data;
  logic          empty, full, overflow, frame_err;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_with_buffer #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par);
`else
    if (par) rx = 1'b1;
`endif
    bit_time(stop);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    repeat (CPB) @(posedge clk);

    // single byte
    send_byte(8'h55);
    settle();
    check("b55_count", count, 1);
    check("b55_data", rd_data, 8'h55);
    check("b55_empty", empty, 0);
    check("b55_ferr", frame_err, 0);
    check("b55_ovf", overflow, 0);
    pop();
    check("b55_pop_empty", empty, 1);
    check("b55_pop_data", rd_data, 8'h00);

    // back-to-back frames
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'hFF);
    settle();
    check("b2b_count3", count, 3);
    check("b2b_d0", rd_data, 8'hA5);
    pop();
    check("b2b_count2", count, 2);
    check("b2b_d1", rd_data, 8'h3C);
    pop();
    check("b2b_d2", rd_data, 8'hFF);
    pop();
    check("b2b_count0", count, 0);

    // overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) send_byte(8'(i));
    settle();
    check("ovf_full", full, 1);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check("ovf_pop_data", rd_data, 32'(i));
      pop();
    end
    check("ovf_drained", empty, 1);
    check("ovf_sticky", overflow, 1);
    pulse_clr();
    check("ovf_cleared", overflow, 0);

    // bad stop bit, then a good byte
    send_frame(8'h81, ^8'h81, 1'b0);
    settle();
    check("fe_flag", frame_err, 1);
    check("fe_empty", empty, 1);
    send_byte(8'h42);
    settle();
    check("fe_next_data", rd_data, 8'h42);
    check("fe_next_count", count, 1);
    pulse_clr();
    check("fe_cleared", frame_err, 0);
    pop();

    // short glitch on idle line
    rx = 1'b0;
    repeat (6) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check("glitch_empty", empty, 1);
    check("glitch_ferr", frame_err, 0);

    // reset in the middle of a frame while the FIFO holds a byte
    send_byte(8'h11);
    settle();
    check("mid_pre_count", count, 1);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(i[0] ? 1'b1 : 1'b0);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    check("mid_empty", empty, 1);
    check("mid_ferr", frame_err, 0);
    check("mid_ovf", overflow, 0);
    send_byte(8'h7E);
    settle();
    check("mid_next_data", rd_data, 8'h7E);
    check("mid_next_ferr", frame_err, 0);
    pop();

    // break: line held low for many bit times
    rx = 1'b0;
    repeat (25 * CPB) @(posedge clk);
    @(negedge clk);
    check("brk_ferr", frame_err, 1);
    check("brk_empty", empty, 1);
    pulse_clr();
    repeat (5 * CPB) @(posedge clk);
    @(negedge clk);
    check("brk_no_repeat", frame_err, 0);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check("brk_release_ferr", frame_err, 0);
    check("brk_release_empty", empty, 1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b0, 1'b1);
    settle();
    check("par_ok_data", rd_data, 8'h03);
    check("par_ok_ferr", frame_err, 0);
    pop();
    send_frame(8'h03, 1'b1, 1'b1);
    settle();
    check("par_bad_ferr", frame_err, 1);
    check("par_bad_empty", empty, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
